// File: rtl/write_buffer_pkg.sv
// Shared CPU types for the store write buffer.
// Holds the default address/data widths and the buffered store record.
// An instance may be built narrower than these defaults. Its unused upper
// record bits are then tied to zero.
package write_buffer_pkg;

  localparam int unsigned WB_ADDR_W = 32;
  localparam int unsigned WB_DATA_W = 32;

  typedef struct packed {
    logic [WB_ADDR_W-1:0] addr;
    logic [WB_DATA_W-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/flex_counter.sv
// Up/down occupancy counter with synchronous clear.
// Ports:
//   CLK, nRST  - clock, asynchronous active-low reset
//   clear      - synchronous zero; has priority over counting
//   countup    - increment by one
//   countdown  - decrement by one (countup wins if both are high)
//   count      - current value
module flex_counter #(
  parameter int unsigned BITS = 4
) (
  input  logic            CLK,
  input  logic            nRST,
  input  logic            clear,
  input  logic            countup,
  input  logic            countdown,
  output logic [BITS-1:0] count
);

  logic [BITS-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (countup) begin
      count_d = count_q + BITS'(1);
    end else if (countdown) begin
      count_d = count_q - BITS'(1);
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/write_buffer.sv
// Store write buffer: a circular FIFO of pending stores with
// first-word fall-through on the head. It also offers a store-to-load
// lookup that returns the youngest held store to the same address.
// Ports:
//   CLK, nRST              - clock, asynchronous active-low reset
//   clear                  - synchronous flush; beats push and pop
//   push/push_addr/push_data - enqueue; dropped when full
//   full, count            - occupancy status
//   out_valid/out_addr/out_data, out_ready - head entry handshake
//   lookup_addr -> lookup_hit/lookup_data   - pending-store check
module write_buffer
  import write_buffer_pkg::*;
#(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned ADDR_W = WB_ADDR_W,
  parameter int unsigned DATA_W = WB_DATA_W
) (
  input  logic                      CLK,
  input  logic                      nRST,
  input  logic                      clear,
  input  logic                      push,
  input  logic [ADDR_W-1:0]         push_addr,
  input  logic [DATA_W-1:0]         push_data,
  output logic                      full,
  output logic                      out_valid,
  output logic [ADDR_W-1:0]         out_addr,
  output logic [DATA_W-1:0]         out_data,
  input  logic                      out_ready,
  input  logic [ADDR_W-1:0]         lookup_addr,
  output logic                      lookup_hit,
  output logic [DATA_W-1:0]         lookup_data,
  output logic [$clog2(DEPTH):0]    count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  // Entry storage is not reset; valid_q masks it from every output.
  wb_entry_t        mem_q [DEPTH];
  logic [DEPTH-1:0] valid_q, valid_d;
  logic [PW-1:0]    head_q, tail_q;
  logic [PW-1:0]    lk_idx;
  logic             push_acc, pop;

  function automatic wb_entry_t make_entry(input logic [ADDR_W-1:0] a,
                                           input logic [DATA_W-1:0] d);
    wb_entry_t e;
    e = '0;
    e.addr[ADDR_W-1:0] = a;
    e.data[DATA_W-1:0] = d;
    return e;
  endfunction

  // Status comes from the occupancy count alone. Pointers are equal both when
  // the buffer is empty and when it is full, so they cannot tell these apart.
  assign full      = (count == CW'(DEPTH));
  assign out_valid = (count != '0);
  assign push_acc  = push & ~full;
  assign pop       = out_valid & out_ready;

  flex_counter #(
    .BITS (CW)
  ) u_occupancy (
    .CLK       (CLK),
    .nRST      (nRST),
    .clear     (clear),
    .countup   (push_acc & ~pop),
    .countdown (pop & ~push_acc),
    .count     (count)
  );

  // Push and pop never hit the same slot. head equals tail only when the
  // buffer is empty (no pop then) or full (no accepted push then).
  always_comb begin
    valid_d = valid_q;
    if (push_acc) valid_d[tail_q] = 1'b1;
    if (pop)      valid_d[head_q] = 1'b0;
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      head_q  <= '0;
      tail_q  <= '0;
      valid_q <= '0;
    end else if (clear) begin
      head_q  <= '0;
      tail_q  <= '0;
      valid_q <= '0;
    end else begin
      if (push_acc) tail_q <= tail_q + PW'(1);
      if (pop)      head_q <= head_q + PW'(1);
      valid_q <= valid_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (push_acc && !clear) begin
      mem_q[tail_q] <= make_entry(push_addr, push_data);
    end
  end

  assign out_addr = mem_q[head_q].addr[ADDR_W-1:0];
  assign out_data = mem_q[head_q].data[DATA_W-1:0];

  // Scan from oldest (head) to youngest; a later match overrides, so the
  // youngest matching store supplies the data.
  always_comb begin
    lookup_hit  = 1'b0;
    lookup_data = '0;
    lk_idx      = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      lk_idx = head_q + PW'(i);
      if (valid_q[lk_idx] && (mem_q[lk_idx].addr[ADDR_W-1:0] == lookup_addr)) begin
        lookup_hit  = 1'b1;
        lookup_data = mem_q[lk_idx].data[DATA_W-1:0];
      end
    end
  end

endmodule

// File: tb/tb_write_buffer.sv
// Self-checking bench for write_buffer (DEPTH=4, 32-bit address/data).
// A queue model predicts all outputs. A negedge process compares them every
// cycle. Literal checks pin the model at the key points.
module tb_write_buffer;

  localparam int unsigned DEPTH = 4;

  logic        CLK, nRST, clear, push, out_ready;
  logic [31:0] push_addr, push_data, lookup_addr;
  logic        full, out_valid, lookup_hit;
  logic [31:0] out_addr, out_data, lookup_data;
  logic [2:0]  count;

  int n_cmp = 0;
  int n_err = 0;

  write_buffer #(
    .DEPTH  (DEPTH),
    .ADDR_W (32),
    .DATA_W (32)
  ) dut (
    .CLK         (CLK),
    .nRST        (nRST),
    .clear       (clear),
    .push        (push),
    .push_addr   (push_addr),
    .push_data   (push_data),
    .full        (full),
    .out_valid   (out_valid),
    .out_addr    (out_addr),
    .out_data    (out_data),
    .out_ready   (out_ready),
    .lookup_addr (lookup_addr),
    .lookup_hit  (lookup_hit),
    .lookup_data (lookup_data),
    .count       (count)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: held stores, oldest first.
  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
  } ent_t;
  ent_t mq[$];
  logic m_pa;

  always @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      mq.delete();
    end else if (clear) begin
      mq.delete();
    end else begin
      m_pa = push && (mq.size() < DEPTH);
      if (mq.size() != 0 && out_ready) void'(mq.pop_front());
      if (m_pa) mq.push_back('{a: push_addr, d: push_data});
    end
  end

  int          c_n;
  logic        c_hit;
  logic [31:0] c_data;

  always @(negedge CLK) begin
    if (nRST) begin
      c_n = mq.size();
      chk("count", 64'(count), 64'(c_n));
      chk("full", 64'(full), 64'(c_n == DEPTH));
      chk("out_valid", 64'(out_valid), 64'(c_n != 0));
      if (c_n != 0) begin
        chk("out_addr", 64'(out_addr), 64'(mq[0].a));
        chk("out_data", 64'(out_data), 64'(mq[0].d));
      end
      c_hit  = 1'b0;
      c_data = '0;
      for (int i = c_n - 1; i >= 0; i--) begin
        if (!c_hit && mq[i].a == lookup_addr) begin
          c_hit  = 1'b1;
          c_data = mq[i].d;
        end
      end
      chk("lookup_hit", 64'(lookup_hit), 64'(c_hit));
      chk("lookup_data", 64'(lookup_data), 64'(c_data));
    end
  end

  // One clock cycle with the given inputs; returns 1 time unit after the edge.
  task automatic step(input logic p, input logic [31:0] a, input logic [31:0] d,
                      input logic r, input logic c);
    push      = p;
    push_addr = a;
    push_data = d;
    out_ready = r;
    clear     = c;
    @(posedge CLK);
    #1;
    push      = 1'b0;
    out_ready = 1'b0;
    clear     = 1'b0;
  endtask

  initial begin
    nRST = 1'b0; clear = 1'b0; push = 1'b0; out_ready = 1'b0;
    push_addr = '0; push_data = '0; lookup_addr = '0;
    #12;
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_full", 64'(full), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_lookup_hit", 64'(lookup_hit), 64'd0);
    chk("rst_lookup_data", 64'(lookup_data), 64'd0);
    nRST = 1'b1;
    @(posedge CLK);
    #1;

    // First push shows up one cycle later.
    step(1'b1, 32'h100, 32'hAAAA0001, 1'b0, 1'b0);
    chk("first_valid", 64'(out_valid), 64'd1);
    chk("first_addr", 64'(out_addr), 64'h100);
    chk("first_data", 64'(out_data), 64'hAAAA0001);
    chk("first_count", 64'(count), 64'd1);
    step(1'b0, '0, '0, 1'b1, 1'b0);
    chk("first_drained", 64'(out_valid), 64'd0);

    // Fill to full, the fifth push is dropped, drain in order.
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 32'h10 + i, 32'hD0 + i, 1'b0, 1'b0);
      if (i == 3) chk("full_after_4", 64'(full), 64'd1);
    end
    chk("count_after_5", 64'(count), 64'd4);
    for (int i = 0; i < 4; i++) begin
      chk("drain_order", 64'(out_addr), 64'(32'h10 + i));
      step(1'b0, '0, '0, 1'b1, 1'b0);
    end
    chk("drained_valid", 64'(out_valid), 64'd0);

    // Push+pop while full drops the push. Steady push+pop wraps both pointers.
    for (int i = 0; i < 4; i++) step(1'b1, 32'h20 + i, 32'hE0 + i, 1'b0, 1'b0);
    step(1'b1, 32'h99, 32'h99, 1'b1, 1'b0);
    chk("full_pushpop_count", 64'(count), 64'd3);
    chk("full_pushpop_head", 64'(out_addr), 64'h21);
    step(1'b0, '0, '0, 1'b1, 1'b0);
    for (int i = 0; i < 6; i++) step(1'b1, 32'h30 + i, 32'hF0 + i, 1'b1, 1'b0);
    chk("steady_count", 64'(count), 64'd2);
    chk("steady_head", 64'(out_addr), 64'h34);
    step(1'b0, '0, '0, 1'b0, 1'b1);

    // Lookup returns the youngest match. A same-cycle push is not visible.
    step(1'b1, 32'h200, 32'h11, 1'b0, 1'b0);
    step(1'b1, 32'h200, 32'h22, 1'b0, 1'b0);
    step(1'b1, 32'h300, 32'h33, 1'b0, 1'b0);
    lookup_addr = 32'h200;
    #1;
    chk("lookup_youngest_hit", 64'(lookup_hit), 64'd1);
    chk("lookup_youngest_data", 64'(lookup_data), 64'h22);
    lookup_addr = 32'h204;
    #1;
    chk("lookup_miss_hit", 64'(lookup_hit), 64'd0);
    chk("lookup_miss_data", 64'(lookup_data), 64'd0);
    lookup_addr = 32'h200;
    step(1'b1, 32'h200, 32'h44, 1'b1, 1'b0);
    chk("lookup_newer_data", 64'(lookup_data), 64'h44);
    step(1'b0, '0, '0, 1'b0, 1'b1);
    step(1'b1, 32'h500, 32'h55, 1'b0, 1'b0);
    lookup_addr = 32'h500;
    #1;
    chk("lookup_before_pop", 64'(lookup_hit), 64'd1);
    step(1'b0, '0, '0, 1'b1, 1'b0);
    chk("lookup_after_pop", 64'(lookup_hit), 64'd0);

    // Clear beats a simultaneous push and pop.
    for (int i = 0; i < 3; i++) step(1'b1, 32'h600 + i, 32'h60 + i, 1'b0, 1'b0);
    lookup_addr = 32'h601;
    chk("pre_clear_count", 64'(count), 64'd3);
    step(1'b1, 32'h700, 32'h77, 1'b1, 1'b1);
    chk("clear_count", 64'(count), 64'd0);
    chk("clear_valid", 64'(out_valid), 64'd0);
    chk("clear_hit", 64'(lookup_hit), 64'd0);
    step(1'b1, 32'h710, 32'h71, 1'b0, 1'b0);
    chk("post_clear_addr", 64'(out_addr), 64'h710);
    step(1'b0, '0, '0, 1'b0, 1'b1);

    // Asynchronous reset in the middle of a drain.
    for (int i = 0; i < 3; i++) step(1'b1, 32'h800 + i, 32'h80 + i, 1'b0, 1'b0);
    lookup_addr = 32'h802;
    step(1'b0, '0, '0, 1'b1, 1'b0);
    #2;
    nRST = 1'b0;
    #1;
    chk("arst_count", 64'(count), 64'd0);
    chk("arst_valid", 64'(out_valid), 64'd0);
    chk("arst_full", 64'(full), 64'd0);
    chk("arst_hit", 64'(lookup_hit), 64'd0);
    chk("arst_data", 64'(lookup_data), 64'd0);
    #3;
    nRST = 1'b1;
    @(posedge CLK);
    #1;
    step(1'b1, 32'h900, 32'h99, 1'b0, 1'b0);
    chk("post_rst_valid", 64'(out_valid), 64'd1);
    chk("post_rst_addr", 64'(out_addr), 64'h900);
    chk("post_rst_count", 64'(count), 64'd1);
    step(1'b0, '0, '0, 1'b1, 1'b0);
    step(1'b0, '0, '0, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
